// File: rtl/mul_radix4.sv
// Sequential 32x32 multiplier: radix-4 Booth, one digit per cycle, LSB digit first.
// Signedness per operand, selectable high/low product word, valid/ready on both sides.
module mul_radix4 (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_in_1_signed,
  input  logic        req_in_2_signed,
  input  logic        req_out_sel,
  input  logic [31:0] req_in_1,
  input  logic [31:0] req_in_2,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_result
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      r_state;
  logic [4:0]  r_cnt;
  logic [65:0] r_acc;
  logic [65:0] r_mcand;
  logic [34:0] r_mplier;
  logic        r_sel;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic [31:0] r_result;

  logic [32:0] w_mcand_ext;
  logic [32:0] w_mplier_ext;
  logic [65:0] w_pp;
  logic        w_neg;
  logic [65:0] w_acc_next;

  assign w_mcand_ext  = {req_in_1_signed & req_in_1[31], req_in_1};
  assign w_mplier_ext = {req_in_2_signed & req_in_2[31], req_in_2};

  // Booth digit from the low triplet of the multiplier shift register.
  always_comb begin
    w_pp  = 66'd0;
    w_neg = 1'b0;
    case (r_mplier[2:0])
      3'b001, 3'b010: w_pp = r_mcand;
      3'b011:         w_pp = {r_mcand[64:0], 1'b0};
      3'b100: begin
        w_pp  = {r_mcand[64:0], 1'b0};
        w_neg = 1'b1;
      end
      3'b101, 3'b110: begin
        w_pp  = r_mcand;
        w_neg = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_acc_next = r_acc + (w_neg ? ~w_pp : w_pp) + {65'd0, w_neg};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= StIdle;
      r_cnt        <= 5'd0;
      r_acc        <= 66'd0;
      r_mcand      <= 66'd0;
      r_mplier     <= 35'd0;
      r_sel        <= 1'b0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_result     <= 32'd0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (req_valid) begin
            r_mcand     <= {{33{w_mcand_ext[32]}}, w_mcand_ext};
            // Multiplier padded to 34 bits, plus the implicit zero below the LSB.
            r_mplier    <= {w_mplier_ext[32], w_mplier_ext, 1'b0};
            r_sel       <= req_out_sel;
            r_acc       <= 66'd0;
            r_cnt       <= 5'd16;
            r_req_ready <= 1'b0;
            r_state     <= StBusy;
          end
        end
        StBusy: begin
          r_acc    <= w_acc_next;
          r_mcand  <= {r_mcand[63:0], 2'b00};
          r_mplier <= {{2{r_mplier[34]}}, r_mplier[34:2]};
          r_cnt    <= r_cnt - 5'd1;
          if (r_cnt == 5'd0) begin
            r_result     <= r_sel ? w_acc_next[63:32] : w_acc_next[31:0];
            r_resp_valid <= 1'b1;
            r_state      <= StDone;
          end
        end
        StDone: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign resp_valid  = r_resp_valid;
  assign resp_result = r_result;

endmodule

// File: tb/tb_mul_radix4.sv
// Self-checking bench for mul_radix4: directed vector table, random ops against
// a plain-arithmetic product model, backpressure and mid-operation reset sequences.
module tb_mul_radix4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_in_1_signed = 1'b0;
  logic        req_in_2_signed = 1'b0;
  logic        req_out_sel = 1'b0;
  logic [31:0] req_in_1 = 32'd0;
  logic [31:0] req_in_2 = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_result;

  int n_tests = 0;
  int n_fail  = 0;

  mul_radix4 dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_in_1_signed (req_in_1_signed),
    .req_in_2_signed (req_in_2_signed),
    .req_out_sel     (req_out_sel),
    .req_in_1        (req_in_1),
    .req_in_2        (req_in_2),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_result     (resp_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          s1;
    bit          s2;
    bit          sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: extend each operand to 64 bits and take the 64-bit product.
  function automatic logic [31:0] model(input bit s1, input bit s2, input bit sel,
                                        input logic [31:0] a, input logic [31:0] b);
    logic [63:0] x, y, p;
    x = s1 ? {{32{a[31]}}, a} : {32'd0, a};
    y = s2 ? {{32{b[31]}}, b} : {32'd0, b};
    p = x * y;
    return sel ? p[63:32] : p[31:0];
  endfunction

  task automatic start_op(input bit s1, input bit s2, input bit sel,
                          input logic [31:0] a, input logic [31:0] b);
    int w;
    w = 0;
    while (!req_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!req_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL start_timeout: req_ready got 0, expected 1");
    end
    req_valid       = 1'b1;
    req_in_1_signed = s1;
    req_in_2_signed = s2;
    req_out_sel     = sel;
    req_in_1        = a;
    req_in_2        = b;
    @(posedge clk); #1;
    // Scramble inputs after acceptance; they must not influence the result.
    req_valid       = 1'b0;
    req_in_1_signed = 1'($urandom_range(0, 1));
    req_in_2_signed = 1'($urandom_range(0, 1));
    req_out_sel     = 1'($urandom_range(0, 1));
    req_in_1        = $urandom;
    req_in_2        = $urandom;
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    while (!resp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string name, input bit s1, input bit s2, input bit sel,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    int          lat;
    logic [31:0] res;
    start_op(s1, s2, sel, a, b);
    wait_resp(lat);
    check({name, "_latency"}, 32'(lat), 32'd17);
    res = resp_result;
    check({name, "_result"}, res, exp);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check({name, "_ready_after"}, {31'd0, req_ready}, 32'd1);
    check({name, "_valid_after"}, {31'd0, resp_valid}, 32'd0);
    check({name, "_hold_after"}, resp_result, res);
  endtask

  initial begin
    int          lat;
    bit          s1, s2, sel, saw_valid;
    logic [31:0] a, b;

    vecs[0]  = '{0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[1]  = '{0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    vecs[2]  = '{1, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    vecs[3]  = '{1, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    vecs[4]  = '{1, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[5]  = '{1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    vecs[6]  = '{1, 1, 1, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[7]  = '{1, 1, 0, 32'h80000000, 32'h80000000, 32'h00000000};
    vecs[8]  = '{1, 1, 0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[9]  = '{1, 1, 1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};
    vecs[10] = '{1, 1, 1, 32'h00000000, 32'h80000000, 32'h00000000};
    vecs[11] = '{0, 1, 1, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFF};
    vecs[12] = '{0, 1, 0, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFF2};
    vecs[13] = '{0, 0, 1, 32'h12345678, 32'h00000010, 32'h00000001};
    vecs[14] = '{0, 0, 0, 32'h12345678, 32'h00000010, 32'h23456780};

    // Reset state
    #12;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_result", resp_result, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].s1, vecs[i].s2, vecs[i].sel,
             vecs[i].a, vecs[i].b, vecs[i].exp);

    for (int i = 0; i < 40; i++) begin
      s1  = 1'($urandom_range(0, 1));
      s2  = 1'($urandom_range(0, 1));
      sel = 1'($urandom_range(0, 1));
      a   = (i % 8 == 0) ? 32'h80000000 : $urandom;
      b   = (i % 8 == 4) ? 32'h80000000 : $urandom;
      run_op($sformatf("rnd%0d", i), s1, s2, sel, a, b, model(s1, s2, sel, a, b));
    end

    // Backpressure: hold DONE for 5 cycles, a request pulse must be ignored
    start_op(1'b0, 1'b0, 1'b0, 32'd7, 32'd6);
    wait_resp(lat);
    check("bp_latency", 32'(lat), 32'd17);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        req_valid = 1'b1;
        req_in_1  = 32'd9;
        req_in_2  = 32'd9;
      end else begin
        req_valid = 1'b0;
      end
      @(posedge clk); #1;
      check($sformatf("bp_valid%0d", c), {31'd0, resp_valid}, 32'd1);
      check($sformatf("bp_result%0d", c), resp_result, 32'h0000002A);
      check($sformatf("bp_req_ready%0d", c), {31'd0, req_ready}, 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("bp_ready_after", {31'd0, req_ready}, 32'd1);
    saw_valid = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (resp_valid) saw_valid = 1'b1;
    end
    check("bp_no_spurious", {31'd0, saw_valid}, 32'd0);

    // Reset during BUSY cycle 8
    start_op(1'b0, 1'b0, 1'b1, 32'h12345678, 32'h9ABCDEF0);
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("mid_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("mid_rst_result", resp_result, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    saw_valid = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (resp_valid) saw_valid = 1'b1;
    end
    check("mid_rst_no_resp", {31'd0, saw_valid}, 32'd0);
    run_op("post_rst", 1'b0, 1'b0, 1'b0, 32'd3, 32'd5, 32'h0000000F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_radix4.md
MUL_RADIX4 -- requirements
Module: mul_radix4

Interface
Parameters: none; operand width fixed at 32.
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Port `clk`, input, 1 bit: sole clock; all state updates on the rising edge.
REQ-003 Port `reset`, input, 1 bit: asynchronous active-low reset; 0 = reset asserted.
REQ-004 Port `req_valid`, input, 1 bit: requester presents an operation.
REQ-005 Port `req_ready`, output, 1 bit: block can accept an operation.
REQ-006 Port `req_in_1_signed`, input, 1 bit: treat `req_in_1` as two's complement.
REQ-007 Port `req_in_2_signed`, input, 1 bit: treat `req_in_2` as two's complement.
REQ-008 Port `req_out_sel`, input, 1 bit: 0 = low product word, 1 = high product word.
REQ-009 Port `req_in_1`, input, 32 bits: multiplicand.
REQ-010 Port `req_in_2`, input, 32 bits: multiplier.
REQ-011 Port `resp_valid`, output, 1 bit: result available.
REQ-012 Port `resp_ready`, input, 1 bit: consumer accepts the result.
REQ-013 Port `resp_result`, output, 32 bits: selected product word.

Function
REQ-014 FSM states: IDLE, BUSY, DONE; `req_ready` = 1 only in IDLE; `resp_valid` = 1 only in DONE.
REQ-015 Accept: `req_valid` & `req_ready` at a rising edge.
  - Captures all `req_*` inputs.
  - Clears the accumulator and loads iteration counter = 16.
  - Enters BUSY.
REQ-016 Inputs are ignored outside IDLE; `req_*` changes after acceptance do not affect the result.
REQ-017 Operand extension: each operand is extended to 33 bits with sign bit = `signed` flag & bit 31.
REQ-018 Algorithm: radix-4 Booth recoding of the 33-bit multiplier, padded to 34 bits; 17 digits in {-2,-1,0,+1,+2}.
REQ-019 One digit per BUSY cycle, LSB digit first; partial products use the 33-bit sign-extended multiplicand.
REQ-020 Accumulator width is 66 bits; the product is bits [63:0] of the exact signed 66-bit result.
REQ-021 BUSY lasts exactly 17 cycles; the counter decrements from 16; the edge processing count 0 enters DONE.
REQ-022 Latency: `resp_valid` rises on the 17th rising edge after the accept edge.
REQ-023 `resp_result` is registered:
  - `req_out_sel` = 0: product[31:0].
  - `req_out_sel` = 1: product[63:32].
  - Stable while `resp_valid` = 1.
REQ-024 In DONE, `resp_valid` & `resp_ready` at an edge returns the FSM to IDLE.
  - `resp_valid` falls; `req_ready` rises the same edge.
  - `resp_result` holds its value until the next DONE.
REQ-025 No request is accepted in the cycle of response handshake; peak throughput is one operation per 19 cycles.
REQ-026 `resp_ready` held 0: DONE is held indefinitely with `resp_result` unchanged.
REQ-027 Zero operands and the most-negative operand (0x80000000 signed) SHALL produce the exact product, with no overflow flag.

Reset
REQ-028 While `reset` = 0, asynchronously:
  - state = IDLE;
  - `req_ready` = 1, `resp_valid` = 0, `resp_result` = 0x00000000;
  - counter and accumulator are cleared.
REQ-029 Reset asserted in BUSY or DONE aborts the operation; no response is issued for it.
REQ-030 After `reset` deasserts, the first accept behaves identically to a post-power-up accept.

Verification
REQ-031 Unsigned × unsigned (`signed` flags 0,0), 0xFFFFFFFF × 0xFFFFFFFF:
  - sel = 1 -> 0xFFFFFFFE; sel = 0 -> 0x00000001.
  - `resp_valid` exactly 17 edges after accept.
REQ-032 Signed × signed, 0xFFFFFFFF × 0xFFFFFFFF (-1 × -1): sel = 1 -> 0x00000000; sel = 0 -> 0x00000001.
REQ-033 Signed × unsigned, 0xFFFFFFFF × 0xFFFFFFFF: sel = 1 -> 0xFFFFFFFF; sel = 0 -> 0x00000001.
REQ-034 Signed × signed, 0x80000000 × 0x80000000: sel = 1 -> 0x40000000; sel = 0 -> 0x00000000.
REQ-035 Backpressure, 7 × 6 sel = 0, `resp_ready` held 0 for 5 cycles in DONE:
  - `resp_valid` = 1 and `resp_result` = 0x0000002A held throughout;
  - `req_ready` = 0 throughout; a `req_valid` pulse during this time is ignored;
  - after the handshake, `req_ready` = 1.
REQ-036 Reset mid-operation: `reset` = 0 at BUSY cycle 8 of 0x12345678 × 0x9ABCDEF0:
  - outputs immediately `req_ready` = 1, `resp_valid` = 0, `resp_result` = 0;
  - a following 3 × 5 sel = 0 returns 0x0000000F after 17 edges.
